// File: rtl/crc8_stream_arbiter.sv
// Round-robin, packet-granular sharing of one MSB-first bit-serial CRC-8 engine among NUM_REQ byte streams.
// 9 cycles per byte (1 fetch + 8 shift); a stalled granted stream holds the engine and other requesters wait.
module crc8_stream_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter logic [7:0]  POLY    = 8'h07,
  parameter logic [7:0]  INIT    = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           crc_out,
  output logic                 crc_valid,
  output logic [ID_W-1:0]      crc_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] crc_id_q, crc_id_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      crc_out_q, crc_out_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            last_flag_q, last_flag_d;

  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            arb_any;
  logic [ID_W-1:0] arb_idx;
  logic            fb;
  logic [7:0]      crc_step;

  // Byte-stream signals of the currently granted requester
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // Lowest index above last_grant wins; otherwise wrap to the lowest index overall.
  always_comb begin
    arb_any = |req_valid;
    arb_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) arb_idx = ID_W'(i);
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(last_grant_q))) arb_idx = ID_W'(i);
    end
  end

  always_comb begin
    fb       = crc_q[7] ^ shreg_q[7];
    crc_step = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arb_any) state_d = ST_FETCH;
      ST_FETCH: if (sel_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == 3'd7) state_d = last_flag_q ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if ((state_q == ST_FETCH) && (grant_q == ID_W'(i))) req_ready[i] = req_valid[i];
    end
    crc_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  assign crc_out = crc_out_q;
  assign crc_id  = crc_id_q;

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    crc_d        = crc_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    last_flag_d  = last_flag_q;
    crc_out_d    = crc_out_q;
    crc_id_d     = crc_id_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          crc_d   = INIT;
        end
      end
      ST_FETCH: begin
        if (sel_valid) begin
          shreg_d     = sel_data;
          last_flag_d = sel_last;
          cnt_d       = 3'd0;
        end
      end
      ST_SHIFT: begin
        crc_d   = crc_step;
        shreg_d = {shreg_q[6:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        // Result registers load on the way into DONE so they are valid during the pulse and hold afterwards.
        if ((cnt_q == 3'd7) && last_flag_q) begin
          crc_out_d = crc_step;
          crc_id_d  = grant_q;
        end
      end
      ST_DONE: begin
        last_grant_d = grant_q;
      end
      default: begin
        grant_d = grant_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      crc_q        <= INIT;
      shreg_q      <= 8'h00;
      cnt_q        <= 3'd0;
      last_flag_q  <= 1'b0;
      crc_out_q    <= 8'h00;
      crc_id_q     <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      crc_q        <= crc_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      last_flag_q  <= last_flag_d;
      crc_out_q    <= crc_out_d;
      crc_id_q     <= crc_id_d;
    end
  end

endmodule

// File: tb/tb_crc8_stream_arbiter.sv
// Directed bench for crc8_stream_arbiter: reference CRC-8 (poly 0x07, init 0) values,
// cycle-exact latency, round-robin order, mid-packet reset and result hold.
module tb_crc8_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  crc_out;
  logic        crc_valid;
  logic [1:0]  crc_id;
  logic        busy;

  int passed = 0;
  int total  = 0;

  crc8_stream_arbiter #(
    .NUM_REQ(4),
    .ID_W(2),
    .POLY(8'h07),
    .INIT(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .crc_out(crc_out),
    .crc_valid(crc_valid),
    .crc_id(crc_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns negedges waited before ready (or -1) and leaves the bench just after the handshake edge.
  task automatic send_byte(input int r, input logic [7:0] d, input logic l,
                           output int waits, inout logic [3:0] seen);
    req_valid[r]      = 1'b1;
    req_data[8*r +: 8] = d;
    req_last[r]       = l;
    waits = -1;
    for (int c = 0; c < 64; c++) begin
      #1;
      seen |= req_ready;
      if (req_ready[r]) begin
        waits = c;
        break;
      end
      @(negedge clk);
    end
    if (waits >= 0) begin
      @(posedge clk);
      #1;
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic wait_crc(output int n, inout logic [3:0] seen);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen |= req_ready;
    end while (!crc_valid && n < 40);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready); else passed++;
    total++; if (crc_valid !== 1'b0) $display("FAIL reset_crc_valid: got %b expected 0", crc_valid); else passed++;
    total++; if (crc_out !== 8'h00) $display("FAIL reset_crc_out: got %h expected 00", crc_out); else passed++;
    total++; if (crc_id !== 2'd0) $display("FAIL reset_crc_id: got %0d expected 0", crc_id); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_req0;
    int waits, n;
    logic [3:0] seen;
    seen = '0;
    send_byte(0, 8'h01, 1'b1, waits, seen);
    total++; if (waits !== 1) $display("FAIL r0_ready_wait: got %0d expected 1", waits); else passed++;
    wait_crc(n, seen);
    total++; if (n !== 9) $display("FAIL r0_latency: got %0d expected 9", n); else passed++;
    total++; if (crc_out !== 8'h07) $display("FAIL r0_crc: got %h expected 07", crc_out); else passed++;
    total++; if (crc_id !== 2'd0) $display("FAIL r0_id: got %0d expected 0", crc_id); else passed++;
    total++; if (seen !== 4'b0001) $display("FAIL r0_ready_bits: got %b expected 0001", seen); else passed++;
    @(negedge clk);
    total++; if (crc_valid !== 1'b0) $display("FAIL r0_pulse_width: got %b expected 0", crc_valid); else passed++;
  endtask

  task automatic test_single_req2;
    int waits, n;
    logic [3:0] seen;
    seen = '0;
    send_byte(2, 8'hFF, 1'b1, waits, seen);
    total++; if (waits !== 1) $display("FAIL r2_ready_wait: got %0d expected 1", waits); else passed++;
    wait_crc(n, seen);
    total++; if (n !== 9) $display("FAIL r2_latency: got %0d expected 9", n); else passed++;
    total++; if (crc_out !== 8'hF3) $display("FAIL r2_crc: got %h expected f3", crc_out); else passed++;
    total++; if (crc_id !== 2'd2) $display("FAIL r2_id: got %0d expected 2", crc_id); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL r2_busy_after: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_multi_byte_req1;
    int waits, n;
    logic [3:0] seen;
    logic gap_ok;
    seen = '0;
    gap_ok = 1'b1;
    for (int b = 0; b < 9; b++) begin
      send_byte(1, 8'h31 + 8'(b), (b == 8), waits, seen);
      total++;
      if (waits !== ((b == 0) ? 1 : 0)) $display("FAIL multi_wait_b%0d: got %0d expected %0d", b, waits, (b == 0) ? 1 : 0);
      else passed++;
      if (b < 8) begin
        for (int c = 0; c < 13; c++) begin
          @(negedge clk);
          seen |= req_ready;
          if (crc_valid !== 1'b0 || busy !== 1'b1) gap_ok = 1'b0;
        end
      end
    end
    wait_crc(n, seen);
    total++; if (gap_ok !== 1'b1) $display("FAIL multi_gap_state: got %b expected 1", gap_ok); else passed++;
    total++; if (n !== 9) $display("FAIL multi_latency: got %0d expected 9", n); else passed++;
    total++; if (crc_out !== 8'hF4) $display("FAIL multi_crc: got %h expected f4", crc_out); else passed++;
    total++; if (crc_id !== 2'd1) $display("FAIL multi_id: got %0d expected 1", crc_id); else passed++;
    total++; if (seen !== 4'b0010) $display("FAIL multi_ready_bits: got %b expected 0010", seen); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_id [3];
    logic [7:0] exp_crc [3];
    logic [1:0] got_id [3];
    logic [7:0] got_crc [3];
    int got_t [3];
    int k;
    exp_id  = '{2'd0, 2'd3, 2'd0};
    exp_crc = '{8'h07, 8'hF3, 8'h07};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_data[7:0]   = 8'h01;
    req_data[31:24] = 8'hFF;
    req_last  = 4'b1001;
    req_valid = 4'b1001;
    k = 0;
    for (int c = 1; c <= 200 && k < 3; c++) begin
      @(negedge clk);
      if (crc_valid) begin
        got_id[k]  = crc_id;
        got_crc[k] = crc_out;
        got_t[k]   = c;
        k++;
      end
    end
    req_valid = '0;
    req_last  = '0;
    total++; if (k !== 3) $display("FAIL b2b_pulses: got %0d expected 3", k); else passed++;
    if (k == 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (got_id[i] !== exp_id[i]) $display("FAIL b2b_id%0d: got %0d expected %0d", i, got_id[i], exp_id[i]); else passed++;
        total++; if (got_crc[i] !== exp_crc[i]) $display("FAIL b2b_crc%0d: got %h expected %h", i, got_crc[i], exp_crc[i]); else passed++;
      end
      total++; if (got_t[0] !== 10) $display("FAIL b2b_first_time: got %0d expected 10", got_t[0]); else passed++;
      total++; if (got_t[1] - got_t[0] !== 11) $display("FAIL b2b_period1: got %0d expected 11", got_t[1] - got_t[0]); else passed++;
      total++; if (got_t[2] - got_t[1] !== 11) $display("FAIL b2b_period2: got %0d expected 11", got_t[2] - got_t[1]); else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet;
    int waits, n;
    logic [3:0] seen;
    logic spurious;
    seen = '0;
    spurious = 1'b0;
    send_byte(1, 8'h5A, 1'b1, waits, seen);
    total++; if (waits !== 1) $display("FAIL rst_mid_wait: got %0d expected 1", waits); else passed++;
    for (int c = 0; c < 5; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
    total++; if (crc_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", crc_valid); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL rst_mid_ready: got %b expected 0000", req_ready); else passed++;
    total++; if (crc_out !== 8'h00) $display("FAIL rst_mid_crc_out: got %h expected 00", crc_out); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (crc_valid) spurious = 1'b1;
    end
    total++; if (spurious !== 1'b0) $display("FAIL rst_mid_no_pulse: got %b expected 0", spurious); else passed++;
    send_byte(1, 8'h01, 1'b1, waits, seen);
    wait_crc(n, seen);
    total++; if (n !== 9) $display("FAIL rst_mid_next_latency: got %0d expected 9", n); else passed++;
    total++; if (crc_out !== 8'h07) $display("FAIL rst_mid_next_crc: got %h expected 07", crc_out); else passed++;
    total++; if (crc_id !== 2'd1) $display("FAIL rst_mid_next_id: got %0d expected 1", crc_id); else passed++;
    @(negedge clk);
  endtask

  task automatic test_zero_data;
    int waits, n;
    logic [3:0] seen;
    logic held_ok;
    seen = '0;
    held_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (crc_out !== 8'h07) held_ok = 1'b0;
    end
    send_byte(0, 8'h00, 1'b1, waits, seen);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!crc_valid && crc_out !== 8'h07) held_ok = 1'b0;
    end while (!crc_valid && n < 40);
    total++; if (held_ok !== 1'b1) $display("FAIL zero_prev_hold: got %b expected 1", held_ok); else passed++;
    total++; if (n !== 9) $display("FAIL zero_latency: got %0d expected 9", n); else passed++;
    total++; if (crc_out !== 8'h00) $display("FAIL zero_crc: got %h expected 00", crc_out); else passed++;
    total++; if (crc_id !== 2'd0) $display("FAIL zero_id: got %0d expected 0", crc_id); else passed++;
    for (int c = 0; c < 3; c++) @(negedge clk);
    total++; if (crc_out !== 8'h00) $display("FAIL zero_hold_after: got %h expected 00", crc_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zero_idle_after: got %b expected 0", busy); else passed++;
  endtask

  initial begin
    test_reset;
    test_single_req0;
    test_single_req2;
    test_multi_byte_req1;
    test_back_to_back;
    test_reset_mid_packet;
    test_zero_data;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/crc8_stream_arbiter.md
Name: crc8_stream_arbiter

Overview:
- Shares one bit-serial CRC-8 engine between NUM_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity. A granted requester keeps the engine until its byte marked last has been shifted in.
- Each byte is shifted MSB-first, one bit per clock. The final CRC is reported with the id of the requester that owned the packet.
- Sits between the packet framers and the link-layer checksum insert/check logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of crc_id; must satisfy 2**ID_W >= NUM_REQ.
- POLY, 8'h07, CRC-8 generator polynomial, implicit x^8 term.
- INIT, 8'h00, CRC register value loaded at the start of each packet.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8*i+7:8*i].
- req_last  input  NUM_REQ  byte is the last of its packet; qualified by req_valid.
- req_ready  output  NUM_REQ  byte accepted this cycle; at most one bit high.
- crc_out  output  8  final packet CRC; meaningful only while crc_valid is high.
- crc_valid  output  1  one-cycle pulse, packet CRC complete.
- crc_id  output  ID_W  requester index for crc_out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; crc register=INIT; bit counter=0; grant=0.
  - last_grant=NUM_REQ-1, so requester 0 has priority first.
  - Outputs: req_ready=0, crc_valid=0, crc_out=0, crc_id=0, busy=0.
  - Reset mid-packet abandons the packet. No crc_valid is produced for it.
- IDLE:
  - If any req_valid is high, grant = first set index searching from last_grant+1, wrapping modulo NUM_REQ.
  - Load crc=INIT and go to FETCH. No byte is accepted in this cycle.
  - If no req_valid is high, stay in IDLE.
- FETCH:
  - req_ready[grant] = req_valid[grant], combinational from state and grant. All other ready bits are 0.
  - On handshake: latch the byte into the shift register, latch last_flag=req_last[grant], clear the bit counter, go to SHIFT.
  - If req_valid[grant] is low, wait in FETCH indefinitely. Grant is held and other requesters are ignored; no timeout.
- SHIFT (8 cycles, counter 0..7), per cycle:
  - bit = shreg[7]; fb = crc[7] ^ bit.
  - crc = {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
  - shreg shifts left by one.
  - On counter==7: if last_flag go to DONE, else go to FETCH.
- DONE (1 cycle):
  - crc_valid=1, crc_out=crc, crc_id=grant.
  - last_grant=grant; go to IDLE.
  - crc_out and crc_id hold their values until the next DONE.
- Throughput:
  - Minimum 9 cycles per byte: 1 FETCH + 8 SHIFT.
  - Single-byte packet: handshake at cycle t, crc_valid at t+9.
  - Re-arbitration costs 1 IDLE cycle after DONE.
- Changes to req_valid or req_last of non-granted requesters have no effect mid-packet.
- A requester may drop req_valid between bytes; the packet continues when valid returns.
- Simultaneous requests are resolved purely by the round-robin pointer. The requester just served has the lowest priority next.
- No CRC final XOR and no bit reflection.

Test Plan:
- Reset, then req0 sends single byte 0x01 with last -> req_ready[0] one cycle; crc_valid exactly 9 cycles after the handshake; crc_out=0x07, crc_id=0.
- req2 sends single byte 0xFF with last -> crc_out=0xF3, crc_id=2; busy low again 1 cycle after crc_valid.
- req1 sends ASCII "123456789" (0x31..0x39), last on 0x39, inserting 5-cycle valid gaps between bytes -> crc_out=0xF4, crc_id=1; no other ready bit ever asserts.
- Back-to-back fairness:
  - Stimulus: req0 and req3 both hold single-byte packets valid continuously.
  - Expected order out of reset: req0, then req3, then req0.
  - The two CRCs must match the standalone results for the same bytes.
- Reset mid-operation: assert rst_n low during SHIFT counter=4 of req1's packet -> all outputs 0 immediately, no crc_valid; the next packet 0x01 from req1 yields 0x07.
- Zero-data packet: byte 0x00 with last from req0 -> crc_out=0x00 (INIT=0); check that crc_out from the previous packet stays held until this DONE.
